// File: rtl/ann_layer_mac_if.sv
// Bus bundle between the ANN layer MAC, its image/weight SRAM read ports and the
// result consumer; the slave modport is the MAC side.
interface ann_layer_mac_if #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 16,
  parameter int DW    = 16
);
  // start and p_done are single-cycle pulses, result_valid is a one-cycle strobe
  // qualifying result_idx/result_data (no backpressure), and *_data must return
  // the word addressed by *_addr exactly one clock after that address is presented.
  logic                             start;
  logic [$clog2(N_IN)-1:0]          image_addr;
  logic [DW-1:0]                    image_data;
  logic [$clog2(N_IN*N_OUT)-1:0]    weight_addr;
  logic [DW-1:0]                    weight_data;
  logic                             busy;
  logic                             result_valid;
  logic [$clog2(N_OUT)-1:0]         result_idx;
  logic [DW-1:0]                    result_data;
  logic                             p_done;

  modport slave (
    input  start, image_data, weight_data,
    output image_addr, weight_addr, busy, result_valid, result_idx, result_data, p_done
  );

  modport master (
    output start, image_data, weight_data,
    input  image_addr, weight_addr, busy, result_valid, result_idx, result_data, p_done
  );
endinterface

// File: rtl/ann_layer_mac.sv
// Fully-connected layer MAC: streams pixels/weights from synchronous SRAM ports,
// accumulates one dot product per neuron, then scales, saturates and ReLU-clamps.
module ann_layer_mac #(
  parameter int N_IN      = 64,
  parameter int N_OUT     = 16,
  parameter int DW        = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  ann_layer_mac_if.slave   bus,
  output logic [2:0]       dbg_state
);
  localparam int IAW   = $clog2(N_IN);
  localparam int WAW   = $clog2(N_IN * N_OUT);
  localparam int NW    = $clog2(N_OUT);
  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + $clog2(N_IN);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [IAW-1:0]          image_addr;
  logic [WAW-1:0]          weight_addr;
  logic [NW-1:0]           neuron;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] scaled;
  logic [DW-1:0]           result;
  logic                    result_valid;
  logic [NW-1:0]           result_idx;
  logic [DW-1:0]           result_data;
  logic                    p_done;
  logic                    last_pixel;
  logic                    last_neuron;
  logic                    add_en;
  logic                    start_ok;

  // image_addr doubles as the pixel counter i; weight_addr runs contiguously across neurons.
  assign last_pixel  = (image_addr == IAW'(N_IN - 1));
  assign last_neuron = (neuron == NW'(N_OUT - 1));
  assign add_en      = ((state == S_RUN) && (image_addr != '0)) || (state == S_DRAIN);
  // A start landing while the done pulse is still visible belongs to the finished pass.
  assign start_ok    = bus.start && !p_done;

  assign product     = $signed(bus.image_data) * $signed(bus.weight_data);
  assign product_ext = {{(ACC_W-PW){product[PW-1]}}, product};
  assign scaled      = acc >>> FRAC_BITS;

  always_comb begin
    result = scaled[DW-1:0];
    if (scaled > SAT_MAX) begin
      result = SAT_MAX[DW-1:0];
    end else if (scaled < SAT_MIN) begin
      result = SAT_MIN[DW-1:0];
    end
    if ((RELU != 0) && result[DW-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (last_pixel) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_EMIT;
      S_EMIT:  state_nxt = last_neuron ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      image_addr   <= '0;
      weight_addr  <= '0;
      neuron       <= '0;
      acc          <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_data  <= '0;
      p_done       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      p_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            image_addr  <= '0;
            weight_addr <= '0;
            neuron      <= '0;
            acc         <= '0;
          end
        end
        S_RUN: begin
          if (add_en) acc <= acc + product_ext;
          if (!last_pixel) begin
            image_addr  <= image_addr + IAW'(1);
            weight_addr <= weight_addr + WAW'(1);
          end
        end
        S_DRAIN: begin
          acc <= acc + product_ext;
        end
        S_EMIT: begin
          result_valid <= 1'b1;
          result_idx   <= neuron;
          result_data  <= result;
          acc          <= '0;
          if (!last_neuron) begin
            neuron      <= neuron + NW'(1);
            image_addr  <= '0;
            weight_addr <= weight_addr + WAW'(1);
          end
        end
        S_DONE: begin
          p_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.image_addr   = image_addr;
  assign bus.weight_addr  = weight_addr;
  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = result_valid;
  assign bus.result_idx   = result_idx;
  assign bus.result_data  = result_data;
  assign bus.p_done       = p_done;
  assign dbg_state        = state;
endmodule

// File: tb/tb_ann_layer_mac.sv
// Bench for ann_layer_mac: a ReLU and a linear instance share SRAM models and are
// scored against a dot-product reference computed with plain integer arithmetic.
module tb_ann_layer_mac;
  localparam int N_IN     = 64;
  localparam int N_OUT    = 16;
  localparam int DW       = 16;
  localparam int FRAC     = 8;
  localparam int PASS_LEN = N_IN + 2;
  localparam int DONE_CYC = N_OUT * PASS_LEN + 1;

  typedef struct packed {
    logic        dut;
    logic [3:0]  idx;
    logic [11:0] cyc;
    logic [15:0] data;
  } strobe_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] dbg0, dbg1;

  ann_layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) b0 ();
  ann_layer_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) b1 ();

  ann_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC_BITS(FRAC), .RELU(1)) u_relu (
    .clk(clk), .n_rst(n_rst), .bus(b0), .dbg_state(dbg0)
  );
  ann_layer_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC_BITS(FRAC), .RELU(0)) u_lin (
    .clk(clk), .n_rst(n_rst), .bus(b1), .dbg_state(dbg1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  int pass_e0  = 0;
  int checks   = 0;
  int errors   = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- SRAM models ----------------
  logic signed [DW-1:0] image_mem  [N_IN];
  logic signed [DW-1:0] weight_mem [N_IN*N_OUT];

  always @(posedge clk) begin
    b0.image_data  <= image_mem[b0.image_addr];
    b0.weight_data <= weight_mem[b0.weight_addr];
    b1.image_data  <= image_mem[b1.image_addr];
    b1.weight_data <= weight_mem[b1.weight_addr];
  end

  // ---------------- monitor ----------------
  strobe_t exp_q[$];
  strobe_t obs_q[$];
  int      pd_cnt [2] = '{0, 0};
  int      pd_cyc [2] = '{0, 0};

  always @(negedge clk) begin
    if (b0.result_valid) obs_q.push_back({1'b0, b0.result_idx, 12'(edge_cnt - pass_e0), b0.result_data});
    if (b1.result_valid) obs_q.push_back({1'b1, b1.result_idx, 12'(edge_cnt - pass_e0), b1.result_data});
    if (b0.p_done) begin pd_cnt[0] = pd_cnt[0] + 1; pd_cyc[0] = edge_cnt - pass_e0; end
    if (b1.p_done) begin pd_cnt[1] = pd_cnt[1] + 1; pd_cyc[1] = edge_cnt - pass_e0; end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_neuron(input int n, input bit relu);
    longint sum = 0;
    longint q;
    for (int i = 0; i < N_IN; i++)
      sum += longint'(image_mem[i]) * longint'(weight_mem[n*N_IN + i]);
    q = sum >>> FRAC;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return 16'(q);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_const(input logic [15:0] img, input logic [15:0] wt);
    for (int i = 0; i < N_IN; i++) image_mem[i] = img;
    for (int i = 0; i < N_IN*N_OUT; i++) weight_mem[i] = wt;
  endtask

  task automatic load_random(input int span);
    int v;
    for (int i = 0; i < N_IN; i++) begin
      v = int'($urandom_range(0, 2*span - 1)) - span;
      image_mem[i] = 16'(v);
    end
    for (int i = 0; i < N_IN*N_OUT; i++) begin
      v = int'($urandom_range(0, 2*span - 1)) - span;
      weight_mem[i] = 16'(v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    b0.start = 1'b1; b1.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    pass_e0 = edge_cnt;
  endtask

  // One full pass on both instances, scored against the reference; first_obs
  // returns where this pass's strobes begin in obs_q.
  task automatic run_pass(input string name, input bit repulse, output int first_obs);
    int rel;
    int pb0, pb1, ob;
    exp_q.delete();
    for (int n = 0; n < N_OUT; n++)
      for (int d = 0; d < 2; d++)
        exp_q.push_back({1'(d), 4'(n), 12'((n+1)*PASS_LEN), ref_neuron(n, d == 0)});
    ob  = obs_q.size();
    pb0 = pd_cnt[0];
    pb1 = pd_cnt[1];
    first_obs = ob;
    pulse_start();
    rel = 0;
    while (rel < DONE_CYC + 70) begin
      @(negedge clk);
      rel = edge_cnt - pass_e0;
      if (repulse && (rel == 9 || rel == DONE_CYC - 1)) begin
        b0.start = 1'b1; b1.start = 1'b1;
      end else begin
        b0.start = 1'b0; b1.start = 1'b0;
      end
      if (rel == 1) begin
        checks++;
        if ({b0.busy, b1.busy} !== 2'b11) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b expected 11", name, {b0.busy, b1.busy});
        end
      end
    end
    #1;
    checks++;
    if (obs_q.size() - ob !== exp_q.size()) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d expected %0d", name, obs_q.size() - ob, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (ob + k < obs_q.size()) begin
        checks++;
        if ({obs_q[ob+k].dut, obs_q[ob+k].idx} !== {exp_q[k].dut, exp_q[k].idx}) begin
          errors++;
          $display("FAIL %s idx[%0d]: got dut%0d/%0d expected dut%0d/%0d", name, k,
                   obs_q[ob+k].dut, obs_q[ob+k].idx, exp_q[k].dut, exp_q[k].idx);
        end
        checks++;
        if (obs_q[ob+k].data !== exp_q[k].data) begin
          errors++;
          $display("FAIL %s data[%0d]: got %h expected %h", name, k, obs_q[ob+k].data, exp_q[k].data);
        end
        checks++;
        if (obs_q[ob+k].cyc !== exp_q[k].cyc) begin
          errors++;
          $display("FAIL %s cycle[%0d]: got %0d expected %0d", name, k, obs_q[ob+k].cyc, exp_q[k].cyc);
        end
      end
    end
    checks++;
    if ((pd_cnt[0] - pb0 !== 1) || (pd_cnt[1] - pb1 !== 1)) begin
      errors++;
      $display("FAIL %s p_done_count: got %0d/%0d expected 1/1", name, pd_cnt[0] - pb0, pd_cnt[1] - pb1);
    end
    checks++;
    if ((pd_cyc[0] !== DONE_CYC) || (pd_cyc[1] !== DONE_CYC)) begin
      errors++;
      $display("FAIL %s p_done_cycle: got %0d/%0d expected %0d", name, pd_cyc[0], pd_cyc[1], DONE_CYC);
    end
    checks++;
    if ({b0.busy, b1.busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after_pass: busy got %b expected 00", name, {b0.busy, b1.busy});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    b0.start = 1'b0; b1.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({b0.busy, b0.result_valid, b0.p_done, b0.image_addr, b0.weight_addr, b0.result_idx, b0.result_data} !== '0) begin
      errors++;
      $display("FAIL reset_relu_outputs: got %h expected 0",
               {b0.busy, b0.result_valid, b0.p_done, b0.image_addr, b0.weight_addr, b0.result_idx, b0.result_data});
    end
    checks++;
    if ({b1.busy, b1.result_valid, b1.p_done, b1.image_addr, b1.weight_addr, b1.result_idx, b1.result_data} !== '0) begin
      errors++;
      $display("FAIL reset_lin_outputs: got %h expected 0",
               {b1.busy, b1.result_valid, b1.p_done, b1.image_addr, b1.weight_addr, b1.result_idx, b1.result_data});
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_uniform();
    int fo;
    load_const(16'h0100, 16'h0100);
    run_pass("uniform", 1'b0, fo);
    checks++;
    if (fo < obs_q.size() && obs_q[fo].data !== 16'h4000) begin
      errors++;
      $display("FAIL uniform_anchor: got %h expected 4000", obs_q[fo].data);
    end
  endtask

  task automatic test_row_scaled();
    int fo;
    for (int i = 0; i < N_IN; i++) image_mem[i] = 16'h0010;
    for (int n = 0; n < N_OUT; n++)
      for (int i = 0; i < N_IN; i++) weight_mem[n*N_IN + i] = 16'(n * 256);
    run_pass("row_scaled", 1'b0, fo);
    checks++;
    if (fo + 31 < obs_q.size() && obs_q[fo+31].data !== 16'h3C00) begin
      errors++;
      $display("FAIL row_scaled_idx15: got %h expected 3c00", obs_q[fo+31].data);
    end
  endtask

  task automatic test_saturation();
    int fo;
    load_const(16'h7FFF, 16'h7FFF);
    run_pass("sat_pos", 1'b0, fo);
  endtask

  task automatic test_negative();
    int fo;
    load_const(16'h0100, 16'hFF00);
    run_pass("negative", 1'b0, fo);
    checks++;
    if (fo + 1 < obs_q.size() && {obs_q[fo].data, obs_q[fo+1].data} !== 32'h0000_C000) begin
      errors++;
      $display("FAIL negative_anchor: got %h expected 0000c000", {obs_q[fo].data, obs_q[fo+1].data});
    end
    load_const(16'h7FFF, 16'h8000);
    run_pass("sat_neg", 1'b0, fo);
    checks++;
    if (fo + 1 < obs_q.size() && {obs_q[fo].data, obs_q[fo+1].data} !== 32'h0000_8000) begin
      errors++;
      $display("FAIL sat_neg_anchor: got %h expected 00008000", {obs_q[fo].data, obs_q[fo+1].data});
    end
  endtask

  task automatic test_random();
    int fo;
    load_random(512);
    run_pass("random_mid", 1'b0, fo);
    load_random(32768);
    run_pass("random_full", 1'b0, fo);
  endtask

  task automatic test_back_to_back();
    int fo;
    load_const(16'h0100, 16'h0100);
    run_pass("start_while_busy", 1'b1, fo);
    run_pass("restart_after_done", 1'b0, fo);
  endtask

  task automatic test_reset_abort();
    int rel, ob, pb0, pb1, fo;
    load_const(16'h0100, 16'h0100);
    pulse_start();
    rel = 0;
    while (rel < 199) begin
      @(negedge clk);
      rel = edge_cnt - pass_e0;
    end
    checks++;
    if ({b0.busy, b1.busy, b1.result_data} !== {2'b11, 16'h4000}) begin
      errors++;
      $display("FAIL abort_pre_state: got %h expected 34000", {b0.busy, b1.busy, b1.result_data});
    end
    ob  = obs_q.size();
    pb0 = pd_cnt[0];
    pb1 = pd_cnt[1];
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({b0.busy, b0.result_valid, b0.p_done, b0.image_addr, b0.weight_addr, b0.result_idx, b0.result_data,
         b1.busy, b1.result_valid, b1.p_done, b1.image_addr, b1.weight_addr, b1.result_idx, b1.result_data} !== '0) begin
      errors++;
      $display("FAIL abort_async_clear: got %h/%h expected 0/0",
               {b0.image_addr, b0.weight_addr, b0.result_idx, b0.result_data},
               {b1.image_addr, b1.weight_addr, b1.result_idx, b1.result_data});
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    checks++;
    if ((obs_q.size() !== ob) || (pd_cnt[0] !== pb0) || (pd_cnt[1] !== pb1) || ({b0.busy, b1.busy} !== 2'b00)) begin
      errors++;
      $display("FAIL abort_quiet: got strobes %0d p_done %0d/%0d busy %b expected 0 0/0 00",
               obs_q.size() - ob, pd_cnt[0] - pb0, pd_cnt[1] - pb1, {b0.busy, b1.busy});
    end
    run_pass("abort_recover", 1'b0, fo);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    b0.start = 1'b0;
    b1.start = 1'b0;
    test_reset();
    test_uniform();
    test_row_scaled();
    test_saturation();
    test_negative();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
